// File: rtl/pair_lane_serializer.sv
// Buffers 2*NPAIRS-bit words in a small FIFO and replays each as NPAIRS 2-bit I1/I2 beats.
// Define PAIR_PARITY_EN to append a per-word parity beat {^odd bits, ^even bits}.
module pair_lane_serializer #(
  parameter int NPAIRS = 6,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*NPAIRS-1:0]        in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_i1,
  output logic                       out_i2,
  output logic                       out_first,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int W  = 2 * NPAIRS;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(NPAIRS + 1);
`ifdef PAIR_PARITY_EN
  localparam int NBEATS = NPAIRS + 1;
`else
  localparam int NBEATS = NPAIRS;
`endif
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic [W-1:0]    word_q, word_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [1:0]      pair_sel;
  logic            full, empty, push, pop, beat_accept, last_beat;

  assign full        = (count_q == LW'(DEPTH));
  assign empty       = (count_q == '0);
  assign in_ready    = !full;
  assign push        = in_valid && !full;
  assign out_valid   = (state_q == SEND);
  assign beat_accept = out_valid && out_ready;
  assign last_beat   = (beat_q == LAST_BEAT);
  // The shifter refills from the FIFO when idle or right as the last beat leaves.
  assign pop         = !empty && ((state_q == IDLE) || (beat_accept && last_beat));
  assign fifo_level  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + LW'(push) - LW'(pop);
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = SEND;
          beat_d  = '0;
          word_d  = mem[rd_ptr_q];
        end
      end
      SEND: begin
        if (beat_accept) begin
          if (last_beat) begin
            beat_d = '0;
            if (!empty) begin
              word_d = mem[rd_ptr_q];
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef PAIR_PARITY_EN
    logic par_even;
    logic par_odd;
    par_even = 1'b0;
    par_odd  = 1'b0;
    for (int k = 0; k < NPAIRS; k++) begin
      par_even = par_even ^ word_q[2*k];
      par_odd  = par_odd ^ word_q[2*k+1];
    end
`endif
    pair_sel = 2'b00;
    for (int k = 0; k < NPAIRS; k++) begin
      if (beat_q == BW'(k)) pair_sel = word_q[2*k +: 2];
    end
`ifdef PAIR_PARITY_EN
    if (beat_q == BW'(NPAIRS)) pair_sel = {par_odd, par_even};
`endif
  end

  assign out_i1    = out_valid && pair_sel[0];
  assign out_i2    = out_valid && pair_sel[1];
  assign out_first = out_valid && (beat_q == '0);
  assign out_last  = out_valid && last_beat;

  // Storage is left unreset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      word_q   <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      word_q   <= word_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: tb/tb_pair_lane_serializer.sv
// Randomized and directed bench for pair_lane_serializer against a word-to-beat queue model.
// Honours PAIR_PARITY_EN the same way as the design.
module tb_pair_lane_serializer;

  localparam int NPAIRS = 6;
  localparam int DEPTH  = 4;
  localparam int W      = 2 * NPAIRS;
  localparam int LW     = $clog2(DEPTH + 1);
`ifdef PAIR_PARITY_EN
  localparam int NBEATS = NPAIRS + 1;
`else
  localparam int NBEATS = NPAIRS;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_i1, out_i2, out_first, out_last;
  logic [LW-1:0] fifo_level;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Expected beats, each {i2, i1, first, last}, in the order they must leave.
  logic [3:0] exp_q[$];
  logic       last_push;
  logic       stall_prev = 1'b0;
  logic [4:0] outs_prev = '0;

  pair_lane_serializer #(.NPAIRS(NPAIRS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_i1(out_i1), .out_i2(out_i2),
    .out_first(out_first), .out_last(out_last), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_push(input logic [W-1:0] w);
    logic pe, po;
    pe = 1'b0;
    po = 1'b0;
    for (int k = 0; k < NPAIRS; k++) begin
      exp_q.push_back({w[2*k+1], w[2*k], k == 0, k == NBEATS - 1});
      pe ^= w[2*k];
      po ^= w[2*k+1];
    end
`ifdef PAIR_PARITY_EN
    exp_q.push_back({po, pe, 1'b0, 1'b1});
`endif
  endfunction

  // One clock: sample handshakes just before the edge, update the model after it.
  task automatic cycle();
    logic       acc_in, acc_out, rst_edge;
    logic [3:0] e;
    #1;
    rst_edge = !rst_n;
    acc_in   = in_valid && in_ready && rst_n;
    acc_out  = out_valid && out_ready && rst_n;
    if (out_valid && rst_n) check("valid_with_data", 32'(exp_q.size() != 0), 32'd1);
    if (acc_out && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("beat", 32'({out_i2, out_i1, out_first, out_last}), 32'(e));
    end
    stall_prev = out_valid && !out_ready && rst_n;
    outs_prev  = {out_valid, out_i2, out_i1, out_first, out_last};
    @(posedge clk);
    if (rst_edge) exp_q.delete();
    if (acc_in) model_push(in_data);
    last_push = acc_in;
    @(negedge clk);
    if (stall_prev && rst_n)
      check("stall_hold", 32'({out_valid, out_i2, out_i1, out_first, out_last}), 32'(outs_prev));
    check("level_bound", 32'(fifo_level <= LW'(DEPTH)), 32'd1);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      cycle();
      n++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && !out_valid), 32'd1);
  endtask

  task automatic push_words(input int n, input logic use_fixed, input logic [W-1:0] w0,
                            input logic [W-1:0] w1);
    int pushed, tries;
    pushed = 0;
    tries  = 0;
    while (pushed < n && tries < 50) begin
      in_valid = 1'b1;
      in_data  = use_fixed ? ((pushed == 0) ? w0 : w1) : W'($urandom);
      cycle();
      if (last_push) pushed++;
      tries++;
    end
    in_valid = 1'b0;
    check("push_count", 32'(pushed), 32'(n));
  endtask

  initial begin
    logic [1:0] a5c_pairs [6];
    int         contig;
    // Pairs of 12'hA5C taken LSB-first as {I2,I1}.
    a5c_pairs = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};

    // Reset held with traffic offered.
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = W'($urandom);
      cycle();
    end
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_outs", 32'({out_i1, out_i2, out_first, out_last}), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    cycle();
    check("idle_valid", 32'(out_valid), 32'd0);

    // Single word, latency and exact beat values.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = W'(12'hA5C);
    cycle();
    in_valid = 1'b0;
    check("latency_n1", 32'(out_valid), 32'd0);
    cycle();
    check("latency_n2", 32'(out_valid), 32'd1);
    for (int b = 0; b < NPAIRS; b++) begin
      check("a5c_pair", 32'({out_i2, out_i1}), 32'(a5c_pairs[b]));
      check("a5c_first", 32'(out_first), 32'(b == 0));
      cycle();
    end
`ifdef PAIR_PARITY_EN
    check("a5c_parity", 32'({out_i2, out_i1, out_last}), 32'b111);
    cycle();
`endif
    check("a5c_done", 32'(out_valid), 32'd0);

    // Back-pressure: fill shifter plus FIFO, then release.
    out_ready = 1'b0;
    push_words(5, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) cycle();
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_level", 32'(fifo_level), 32'(DEPTH));
    out_ready = 1'b1;
    contig = 0;
    for (int i = 0; i < 5 * NBEATS; i++) begin
      if (out_valid) contig++;
      cycle();
    end
    check("bp_contiguous", 32'(contig), 32'(5 * NBEATS));
    drain();

    // Back-to-back all-ones then all-zeros.
    out_ready = 1'b0;
    push_words(2, 1'b1, {W{1'b1}}, '0);
    cycle();
    out_ready = 1'b1;
    contig = 0;
    for (int i = 0; i < 2 * NBEATS; i++) begin
      if (out_valid) contig++;
      cycle();
    end
    check("b2b_contiguous", 32'(contig), 32'(2 * NBEATS));
    drain();

    // Stall on beat 2.
    out_ready = 1'b1;
    push_words(1, 1'b0, '0, '0);
    cycle();
    cycle();
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("stall_valid", 32'(out_valid), 32'd1);
    drain();

    // Reset at beat 3 with two words queued.
    out_ready = 1'b0;
    push_words(3, 1'b0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    out_ready = 1'b1;
    push_words(1, 1'b0, '0, '0);
    cycle();
    check("post_rst_first", 32'({out_valid, out_first}), 32'b11);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
